// File: rtl/risc_controller.sv
// Instruction register, decoder and multi-cycle control FSM for the simple RISC datapath.
// Optional macro RISC_CTRL_ILLEGAL_TRAP_EN: undecoded instructions halt and raise `illegal`.
//
// state     | meaning
// RST       | force PC to zero
// IF1/IF2   | fetch instruction from PC (IR loads at end of IF2)
// UPDATE_PC | advance PC
// DECODE    | pick execution path from {opcode,op}
// MOV_IMM   | Rn <= sximm8
// GET_A/B   | load A (Rn) / B (Rm) operand registers
// CALC      | ALU operation into C (status for CMP)
// WRITE_REG | Rd <= C
// ADDR_CALC | C <= Rn + sximm5
// LOAD_ADDR | data-address register <= C
// MEM_RD1/2 | read memory, Rd <= mdata
// STR_GETB  | B <= Rd
// STR_CALC  | C <= B
// MEM_WR    | write C to memory
// HALT      | stopped until reset
module risc_controller #(
  parameter logic [1:0] MEM_NONE  = 2'b00,
  parameter logic [1:0] MEM_READ  = 2'b01,
  parameter logic [1:0] MEM_WRITE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic [1:0]  shift,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic        halted
);

  typedef enum logic [4:0] {
    RST, IF1, IF2, UPDATE_PC, DECODE, MOV_IMM, GET_A, GET_B, CALC, WRITE_REG,
    ADDR_CALC, LOAD_ADDR, MEM_RD1, MEM_RD2, STR_GETB, STR_CALC, MEM_WR, HALT
  } state_t;

  state_t      state, nxt;
  logic [15:0] ir;
  logic        load_ir;
  logic [4:0]  opx;

  logic [2:0] readnum_d, writenum_d;
  logic [3:0] vsel_d;
  logic [1:0] shift_d, alu_d, mem_cmd_d;
  logic write_d, loada_d, loadb_d, asel_d, bsel_d, loadc_d, loads_d;
  logic load_pc_d, reset_pc_d, addr_sel_d, load_addr_d, halted_d, load_ir_d;

  assign opx    = ir[15:11];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    nxt = state;
    if (reset) nxt = RST;
    else begin
      case (state)
        RST:       nxt = IF1;
        IF1:       nxt = IF2;
        IF2:       nxt = UPDATE_PC;
        UPDATE_PC: nxt = DECODE;
        DECODE: begin
          casez (opx)
            5'b11010:                   nxt = MOV_IMM;
            5'b11000, 5'b10111:         nxt = GET_B;
            5'b10100, 5'b10101, 5'b10110,
            5'b01100, 5'b10000:         nxt = GET_A;
            5'b111??:                   nxt = HALT;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
            default:                    nxt = HALT;
`else
            default:                    nxt = IF1;
`endif
          endcase
        end
        MOV_IMM:   nxt = IF1;
        GET_A:     nxt = (opx == 5'b01100 || opx == 5'b10000) ? ADDR_CALC : GET_B;
        GET_B:     nxt = CALC;
        CALC:      nxt = (opx == 5'b10101) ? IF1 : WRITE_REG;
        WRITE_REG: nxt = IF1;
        ADDR_CALC: nxt = LOAD_ADDR;
        LOAD_ADDR: nxt = (ir[15:13] == 3'b011) ? MEM_RD1 : STR_GETB;
        MEM_RD1:   nxt = MEM_RD2;
        MEM_RD2:   nxt = IF1;
        STR_GETB:  nxt = STR_CALC;
        STR_CALC:  nxt = MEM_WR;
        MEM_WR:    nxt = IF1;
        HALT:      nxt = HALT;
        default:   nxt = RST;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    readnum_d = 3'd0;  writenum_d = 3'd0; vsel_d = 4'b0000; shift_d = 2'b00;
    alu_d = 2'b00;     mem_cmd_d = MEM_NONE;
    write_d = 1'b0;    loada_d = 1'b0;   loadb_d = 1'b0;   asel_d = 1'b0;
    bsel_d = 1'b0;     loadc_d = 1'b0;   loads_d = 1'b0;   load_pc_d = 1'b0;
    reset_pc_d = 1'b0; addr_sel_d = 1'b0; load_addr_d = 1'b0; halted_d = 1'b0;
    load_ir_d = 1'b0;
    case (nxt)
      RST:       begin reset_pc_d = 1'b1; load_pc_d = 1'b1; end
      IF1:       begin addr_sel_d = 1'b1; mem_cmd_d = MEM_READ; end
      IF2:       begin addr_sel_d = 1'b1; mem_cmd_d = MEM_READ; load_ir_d = 1'b1; end
      UPDATE_PC: load_pc_d = 1'b1;
      MOV_IMM:   begin vsel_d = 4'b0100; writenum_d = ir[10:8]; write_d = 1'b1; end
      GET_A:     begin readnum_d = ir[10:8]; loada_d = 1'b1; end
      GET_B:     begin readnum_d = ir[2:0]; loadb_d = 1'b1; end
      CALC: begin
        shift_d = ir[4:3];
        loadc_d = 1'b1;
        alu_d   = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        asel_d  = (opx == 5'b11000) || (opx == 5'b10111);
        loads_d = (opx == 5'b10101);
      end
      WRITE_REG: begin vsel_d = 4'b0001; writenum_d = ir[7:5]; write_d = 1'b1; end
      ADDR_CALC: begin bsel_d = 1'b1; loadc_d = 1'b1; end
      LOAD_ADDR: load_addr_d = 1'b1;
      MEM_RD1:   mem_cmd_d = MEM_READ;
      MEM_RD2:   begin
        mem_cmd_d = MEM_READ; vsel_d = 4'b1000; writenum_d = ir[7:5]; write_d = 1'b1;
      end
      STR_GETB:  begin readnum_d = ir[7:5]; loadb_d = 1'b1; end
      STR_CALC:  begin asel_d = 1'b1; loadc_d = 1'b1; end
      MEM_WR:    mem_cmd_d = MEM_WRITE;
      HALT:      halted_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST;
      ir    <= 16'h0000;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (load_ir) ir <= read_data;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
      if (state == DECODE && nxt == HALT && ir[15:13] != 3'b111) illegal <= 1'b1;
`endif
    end
    readnum   <= readnum_d;   writenum <= writenum_d; write   <= write_d;
    vsel      <= vsel_d;      loada    <= loada_d;    loadb   <= loadb_d;
    shift     <= shift_d;     asel     <= asel_d;     bsel    <= bsel_d;
    ALUop     <= alu_d;       loadc    <= loadc_d;    loads   <= loads_d;
    load_pc   <= load_pc_d;   reset_pc <= reset_pc_d; addr_sel <= addr_sel_d;
    load_addr <= load_addr_d; mem_cmd  <= mem_cmd_d;  halted  <= halted_d;
    load_ir   <= load_ir_d;
  end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: walks each instruction class state by state.
module tb_risc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] read_data;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop, mem_cmd;
  logic [15:0] sximm5, sximm8;
  logic        load_pc, reset_pc, addr_sel, load_addr, halted;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  risc_controller dut (
    .clk(clk), .reset(reset), .read_data(read_data),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .sximm5(sximm5), .sximm8(sximm8),
    .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd),
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .halted(halted)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // From a sample taken in IF1, present instr and advance to DECODE.
  task automatic fetch(input logic [15:0] instr);
    read_data = instr;
    step(); step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b1; read_data = 16'hD007;
    step();
    reset = 1'b0;
    n_cmp++; if ({reset_pc, load_pc, write, mem_cmd, halted} !== 6'b11_0_00_0) begin
      n_bad++; $display("FAIL rst_state: got %b want 110000", {reset_pc, load_pc, write, mem_cmd, halted});
    end
    step();
    n_cmp++; if ({addr_sel, mem_cmd, load_pc} !== 4'b1_01_0) begin
      n_bad++; $display("FAIL if1: got %b want 1010", {addr_sel, mem_cmd, load_pc});
    end
    step();
    n_cmp++; if ({addr_sel, mem_cmd} !== 3'b1_01) begin
      n_bad++; $display("FAIL if2: got %b want 101", {addr_sel, mem_cmd});
    end
    step();
    n_cmp++; if ({load_pc, reset_pc, mem_cmd} !== 4'b10_00) begin
      n_bad++; $display("FAIL update_pc: got %b want 1000", {load_pc, reset_pc, mem_cmd});
    end
    step();
    n_cmp++; if ({load_pc, write, mem_cmd, loada, loadb, loadc} !== 7'b0) begin
      n_bad++; $display("FAIL decode_idle: got %b want 0000000", {load_pc, write, mem_cmd, loada, loadb, loadc});
    end
    step();
    n_cmp++; if ({write, writenum, vsel} !== 8'b1_000_0100 || sximm8 !== 16'h0007) begin
      n_bad++; $display("FAIL mov_d007: got %b sximm8 %h want 10000100 sximm8 0007", {write, writenum, vsel}, sximm8);
    end
    step();
    n_cmp++; if ({addr_sel, mem_cmd, write} !== 4'b1_01_0) begin
      n_bad++; $display("FAIL mov_back_if1: got %b want 1010", {addr_sel, mem_cmd, write});
    end
  endtask

  task automatic test_mov_imm();
    fetch(16'hD1FE);
    step();
    n_cmp++; if ({write, writenum, vsel} !== 8'b1_001_0100 || sximm8 !== 16'hFFFE) begin
      n_bad++; $display("FAIL mov_d1fe: got %b sximm8 %h want 10010100 sximm8 fffe", {write, writenum, vsel}, sximm8);
    end
    step();
  endtask

  task automatic test_add();
    fetch(16'hA148);
    step();
    n_cmp++; if ({loada, readnum} !== 4'b1_001) begin
      n_bad++; $display("FAIL add_get_a: got %b want 1001", {loada, readnum});
    end
    step();
    n_cmp++; if ({loadb, readnum} !== 4'b1_000) begin
      n_bad++; $display("FAIL add_get_b: got %b want 1000", {loadb, readnum});
    end
    step();
    n_cmp++; if ({loadc, shift, ALUop, loads, asel, bsel, write} !== 9'b1_01_00_0_0_0_0) begin
      n_bad++; $display("FAIL add_calc: got %b want 101000000", {loadc, shift, ALUop, loads, asel, bsel, write});
    end
    step();
    n_cmp++; if ({write, writenum, vsel, loads} !== 9'b1_010_0001_0) begin
      n_bad++; $display("FAIL add_write_reg: got %b want 101000010", {write, writenum, vsel, loads});
    end
    step();
  endtask

  task automatic test_cmp();
    int cyc;
    int wrote;
    bit seen_loads;
    wrote = 0; seen_loads = 0;
    fetch(16'hA900);
    cyc = 3;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (write) wrote++;
      if (loads) begin
        seen_loads = 1;
        n_cmp++; if (ALUop !== 2'b01 || loadc !== 1'b1) begin
          n_bad++; $display("FAIL cmp_calc: got aluop %b loadc %b want 01 1", ALUop, loadc);
        end
      end
      if (addr_sel && mem_cmd == 2'b01) break;
    end
    n_cmp++; if (cyc !== 7 || wrote !== 0 || seen_loads !== 1'b1) begin
      n_bad++; $display("FAIL cmp_cycles: got cyc %0d writes %0d loads %0d want 7 0 1", cyc, wrote, seen_loads);
    end
  endtask

  task automatic test_mvn();
    fetch(16'hB8E0);
    step();
    n_cmp++; if ({loadb, loada} !== 2'b10) begin
      n_bad++; $display("FAIL mvn_get_b: got %b want 10", {loadb, loada});
    end
    step();
    n_cmp++; if ({ALUop, asel, loads, loadc} !== 5'b11_1_0_1) begin
      n_bad++; $display("FAIL mvn_calc: got %b want 11101", {ALUop, asel, loads, loadc});
    end
    step();
    n_cmp++; if ({write, writenum, vsel} !== 8'b1_111_0001) begin
      n_bad++; $display("FAIL mvn_write: got %b want 11110001", {write, writenum, vsel});
    end
    step();
  endtask

  task automatic test_ldr();
    fetch(16'h6064);
    step();
    n_cmp++; if ({loada, readnum} !== 4'b1_000) begin
      n_bad++; $display("FAIL ldr_get_a: got %b want 1000", {loada, readnum});
    end
    step();
    n_cmp++; if ({bsel, asel, loadc, ALUop, shift} !== 7'b1_0_1_00_00 || sximm5 !== 16'h0004) begin
      n_bad++; $display("FAIL ldr_addr_calc: got %b sximm5 %h want 1010000 0004", {bsel, asel, loadc, ALUop, shift}, sximm5);
    end
    step();
    n_cmp++; if ({load_addr, loadc} !== 2'b10) begin
      n_bad++; $display("FAIL ldr_load_addr: got %b want 10", {load_addr, loadc});
    end
    step();
    n_cmp++; if ({addr_sel, mem_cmd, write} !== 4'b0_01_0) begin
      n_bad++; $display("FAIL ldr_mem_rd1: got %b want 0010", {addr_sel, mem_cmd, write});
    end
    step();
    n_cmp++; if ({write, writenum, vsel, addr_sel, mem_cmd} !== 11'b1_011_1000_0_01) begin
      n_bad++; $display("FAIL ldr_mem_rd2: got %b want 10111000001", {write, writenum, vsel, addr_sel, mem_cmd});
    end
    step();
    n_cmp++; if ({addr_sel, mem_cmd} !== 3'b1_01) begin
      n_bad++; $display("FAIL ldr_back_if1: got %b want 101", {addr_sel, mem_cmd});
    end
  endtask

  task automatic test_str();
    int cyc;
    bit seen_wr;
    seen_wr = 0;
    fetch(16'h8064);
    step(); step(); step();
    cyc = 6;
    n_cmp++; if (load_addr !== 1'b1) begin
      n_bad++; $display("FAIL str_load_addr: got %b want 1", load_addr);
    end
    step(); cyc++;
    n_cmp++; if ({loadb, readnum} !== 4'b1_011) begin
      n_bad++; $display("FAIL str_getb: got %b want 1011", {loadb, readnum});
    end
    step(); cyc++;
    n_cmp++; if ({asel, bsel, loadc, ALUop, shift} !== 7'b1_0_1_00_00) begin
      n_bad++; $display("FAIL str_calc: got %b want 1010000", {asel, bsel, loadc, ALUop, shift});
    end
    for (int i = 0; i < 10; i++) begin
      step(); cyc++;
      if (mem_cmd == 2'b10) begin
        seen_wr = 1;
        n_cmp++; if ({addr_sel, write} !== 2'b00) begin
          n_bad++; $display("FAIL str_mem_wr: got %b want 00", {addr_sel, write});
        end
      end
      if (addr_sel && mem_cmd == 2'b01) break;
    end
    n_cmp++; if (cyc !== 10 || seen_wr !== 1'b1) begin
      n_bad++; $display("FAIL str_cycles: got cyc %0d wr %0d want 10 1", cyc, seen_wr);
    end
  endtask

  task automatic test_reset_mid();
    fetch(16'hA148);
    step(); step(); step();
    n_cmp++; if (loadc !== 1'b1) begin
      n_bad++; $display("FAIL mid_in_calc: got loadc %b want 1", loadc);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if ({reset_pc, load_pc, loadc, write, mem_cmd} !== 6'b11_0_0_00) begin
      n_bad++; $display("FAIL mid_reset_rst: got %b want 110000", {reset_pc, load_pc, loadc, write, mem_cmd});
    end
    step();
  endtask

  task automatic test_halt();
    fetch(16'hE000);
    step();
    for (int i = 0; i < 4; i++) begin
      read_data = 16'hD007;
      n_cmp++; if ({halted, mem_cmd, write, load_pc} !== 5'b1_00_0_0) begin
        n_bad++; $display("FAIL halt_hold%0d: got %b want 10000", i, {halted, mem_cmd, write, load_pc});
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if ({halted, reset_pc} !== 2'b01) begin
      n_bad++; $display("FAIL halt_exit: got %b want 01", {halted, reset_pc});
    end
    step();
  endtask

  task automatic test_illegal();
    fetch(16'h0000);
    step();
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    n_cmp++; if ({halted, illegal, mem_cmd} !== 4'b1_1_00) begin
      n_bad++; $display("FAIL illegal_trap: got %b want 1100", {halted, illegal, mem_cmd});
    end
    step();
    n_cmp++; if ({halted, illegal} !== 2'b11) begin
      n_bad++; $display("FAIL illegal_hold: got %b want 11", {halted, illegal});
    end
`else
    n_cmp++; if ({addr_sel, mem_cmd, halted, write} !== 5'b1_01_0_0) begin
      n_bad++; $display("FAIL nop_to_if1: got %b want 10100", {addr_sel, mem_cmd, halted, write});
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    read_data = 16'h0000;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_ldr();
    test_str();
    test_reset_mid();
    test_halt();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
